// File: rtl/cpu_pkg.sv
// ============================================================================
// cpu_pkg : shared opcode/state types and constants for the CPU controller
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam int unsigned PHASE_COUNT = 8;

  typedef enum logic [2:0] {
    OP_HLT = 3'd0,
    OP_SKZ = 3'd1,
    OP_ADD = 3'd2,
    OP_AND = 3'd3,
    OP_XOR = 3'd4,
    OP_LDA = 3'd5,
    OP_STO = 3'd6,
    OP_JMP = 3'd7
  } opcode_e;

  // Running states carry their phase index in the low three bits.
  typedef enum logic [3:0] {
    S_INST_ADDR  = 4'd0,
    S_INST_FETCH = 4'd1,
    S_INST_LOAD  = 4'd2,
    S_IDLE       = 4'd3,
    S_OP_ADDR    = 4'd4,
    S_OP_FETCH   = 4'd5,
    S_ALU_OP     = 4'd6,
    S_STORE      = 4'd7,
    S_HALTED     = 4'd8
  } state_e;

  function automatic logic is_aluop(input opcode_e op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
  endfunction

endpackage

`default_nettype wire

// File: rtl/cpu_ctrl.sv
// ============================================================================
// cpu_ctrl : eight-phase instruction sequencer with halt/resume for a tiny CPU
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module cpu_ctrl
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] opcode,
  input  logic       zero,
  input  logic       start,
  output logic       addr_sel,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       ld_ir,
  output logic       inc_pc,
  output logic       ld_pc,
  output logic       acc_load,
  output logic       acc_ctrl,
  output logic       data_e,
  output logic       halted,
  output logic [2:0] phase
);

  state_e  state_q;
  state_e  state_d;
  opcode_e op;
  logic    aluop;

  assign op    = opcode_e'(opcode);
  assign aluop = is_aluop(op);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_INST_ADDR;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    addr_sel = 1'b0;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    ld_ir    = 1'b0;
    inc_pc   = 1'b0;
    ld_pc    = 1'b0;
    acc_load = 1'b0;
    acc_ctrl = 1'b0;
    data_e   = 1'b0;
    halted   = 1'b0;
    phase    = state_q[2:0];

    case (state_q)
      S_INST_ADDR: begin
        state_d  = S_INST_FETCH;
        addr_sel = 1'b1;
      end
      S_INST_FETCH: begin
        state_d  = S_INST_LOAD;
        addr_sel = 1'b1;
        mem_rd   = 1'b1;
      end
      S_INST_LOAD: begin
        state_d  = S_IDLE;
        addr_sel = 1'b1;
        mem_rd   = 1'b1;
        ld_ir    = 1'b1;
      end
      S_IDLE: begin
        state_d  = S_OP_ADDR;
        addr_sel = 1'b1;
        mem_rd   = 1'b1;
        ld_ir    = 1'b1;
      end
      S_OP_ADDR: begin
        state_d = (op == OP_HLT) ? S_HALTED : S_OP_FETCH;
        inc_pc  = 1'b1;
      end
      S_OP_FETCH: begin
        state_d = S_ALU_OP;
        mem_rd  = aluop;
      end
      S_ALU_OP: begin
        state_d = S_STORE;
        mem_rd  = aluop;
        inc_pc  = (op == OP_SKZ) && zero;
        ld_pc   = (op == OP_JMP);
        data_e  = (op == OP_STO);
      end
      S_STORE: begin
        state_d  = S_INST_ADDR;
        mem_rd   = aluop;
        acc_load = aluop;
        acc_ctrl = (op == OP_LDA);
        ld_pc    = (op == OP_JMP);
        mem_wr   = (op == OP_STO);
        data_e   = (op == OP_STO);
      end
      S_HALTED: begin
        state_d = start ? S_INST_ADDR : S_HALTED;
        halted  = 1'b1;
        phase   = 3'd0;
      end
      default: begin
        state_d = S_INST_ADDR;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_cpu_ctrl.sv
// ============================================================================
// tb_cpu_ctrl : directed self-checking bench for cpu_ctrl
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_cpu_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] opcode = 3'd0;
  logic       zero = 1'b0;
  logic       start = 1'b0;
  logic       addr_sel, mem_rd, mem_wr, ld_ir, inc_pc, ld_pc;
  logic       acc_load, acc_ctrl, data_e, halted;
  logic [2:0] phase;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cpu_ctrl u_dut (
    .clk      (clk),
    .rst      (rst),
    .opcode   (opcode),
    .zero     (zero),
    .start    (start),
    .addr_sel (addr_sel),
    .mem_rd   (mem_rd),
    .mem_wr   (mem_wr),
    .ld_ir    (ld_ir),
    .inc_pc   (inc_pc),
    .ld_pc    (ld_pc),
    .acc_load (acc_load),
    .acc_ctrl (acc_ctrl),
    .data_e   (data_e),
    .halted   (halted),
    .phase    (phase)
  );

  // Observed strobes: {halted, addr_sel, mem_rd, mem_wr, ld_ir, inc_pc, ld_pc, acc_load, acc_ctrl, data_e}
  function automatic logic [9:0] outs();
    return {halted, addr_sel, mem_rd, mem_wr, ld_ir, inc_pc, ld_pc, acc_load, acc_ctrl, data_e};
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Fetch-half vectors shared by every opcode.
  localparam logic [9:0] E_P0 = 10'b0_100000000;
  localparam logic [9:0] E_P1 = 10'b0_110000000;
  localparam logic [9:0] E_P2 = 10'b0_110100000;
  localparam logic [9:0] E_P3 = 10'b0_110100000;
  localparam logic [9:0] E_P4 = 10'b0_000010000;
  localparam logic [9:0] E_HLT = 10'b1_000000000;

  // Entered at a negedge with the DUT in P0; leaves at a negedge back in P0.
  task automatic run_instr(input string name, input logic [2:0] op, input logic z,
                           input logic [9:0] e5, input logic [9:0] e6, input logic [9:0] e7);
    logic [9:0] exp_v [8];
    exp_v[0] = E_P0; exp_v[1] = E_P1; exp_v[2] = E_P2; exp_v[3] = E_P3;
    exp_v[4] = E_P4; exp_v[5] = e5;   exp_v[6] = e6;   exp_v[7] = e7;
    opcode = op;
    zero   = z;
    for (int p = 0; p < 8; p++) begin
      chk($sformatf("%s_phase%0d", name, p), {13'd0, phase}, p[15:0]);
      chk($sformatf("%s_outs_p%0d", name, p), {6'd0, outs()}, {6'd0, exp_v[p]});
      @(negedge clk);
    end
    chk($sformatf("%s_wrap", name), {13'd0, phase}, 16'd0);
  endtask

  task automatic run_to_halt(input string name);
    opcode = 3'd0;
    for (int p = 0; p < 5; p++) @(negedge clk);
    chk($sformatf("%s_halted", name), {6'd0, outs()}, {6'd0, E_HLT});
    chk($sformatf("%s_phase", name), {13'd0, phase}, 16'd0);
  endtask

  initial begin
    // Reset held: combinational outputs must already reflect P0.
    #2;
    chk("rst_outs", {6'd0, outs()}, {6'd0, E_P0});
    chk("rst_phase", {13'd0, phase}, 16'd0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_hold_outs", {6'd0, outs()}, {6'd0, E_P0});
    rst = 1'b0;

    run_instr("lda", 3'd5, 1'b0, 10'b0_010000000, 10'b0_010000000, 10'b0_010000110);
    run_instr("add", 3'd2, 1'b1, 10'b0_010000000, 10'b0_010000000, 10'b0_010000100);
    run_instr("and", 3'd3, 1'b0, 10'b0_010000000, 10'b0_010000000, 10'b0_010000100);
    run_instr("xor", 3'd4, 1'b1, 10'b0_010000000, 10'b0_010000000, 10'b0_010000100);
    run_instr("skz1", 3'd1, 1'b1, 10'b0_000000000, 10'b0_000010000, 10'b0_000000000);
    run_instr("skz0", 3'd1, 1'b0, 10'b0_000000000, 10'b0_000000000, 10'b0_000000000);
    run_instr("sto", 3'd6, 1'b0, 10'b0_000000000, 10'b0_000000001, 10'b0_001000001);
    start = 1'b1;  // start must be ignored outside HALTED
    run_instr("jmp", 3'd7, 1'b0, 10'b0_000000000, 10'b0_000001000, 10'b0_000001000);
    start = 1'b0;

    // Halt, idle 20 cycles, then resume on a one-cycle start pulse.
    run_to_halt("hlt");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk($sformatf("hlt_wait%0d", i), {6'd0, outs()}, {6'd0, E_HLT});
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("resume_p0", {6'd0, outs()}, {6'd0, E_P0});
    chk("resume_phase", {13'd0, phase}, 16'd0);
    @(negedge clk);
    chk("resume_p1", {13'd0, phase}, 16'd1);
    // Finish that instruction (P1..P7) with a benign ALU opcode.
    opcode = 3'd2;
    for (int p = 1; p < 8; p++) @(negedge clk);
    chk("post_resume_p0", {13'd0, phase}, 16'd0);

    // Asynchronous reset in P6 of STO: back to P0 before any edge, no mem_wr.
    opcode = 3'd6;
    for (int p = 0; p < 6; p++) @(negedge clk);
    chk("sto_at_p6", {13'd0, phase}, 16'd6);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_phase", {13'd0, phase}, 16'd0);
    chk("async_rst_outs", {6'd0, outs()}, {6'd0, E_P0});
    @(negedge clk);
    chk("rst_no_memwr", {15'd0, mem_wr}, 16'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_release_p1", {13'd0, phase}, 16'd1);
    for (int p = 1; p < 8; p++) @(negedge clk);

    // Reset from HALTED.
    run_to_halt("hlt2");
    #1 rst = 1'b1;
    #1;
    chk("halt_rst_outs", {6'd0, outs()}, {6'd0, E_P0});
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("halt_rst_p1", {13'd0, phase}, 16'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cpu_ctrl.md
CPU_CTRL -- requirements
Module: cpu_ctrl

Interface
REQ-001 clk  in  1  system clock; all state changes on its rising edge.
REQ-002 rst  in  1  asynchronous, active-high reset.
REQ-003 opcode  in  3  instruction opcode, instr[7:5], from the instruction register.
REQ-004 zero  in  1  high when the accumulator value is 8'h00.
REQ-005 start  in  1  single-cycle resume pulse, used only in HALTED.
REQ-006 addr_sel  out  1  1 = PC drives the memory address; 0 = IR operand field drives it.
REQ-007 mem_rd  out  1  memory read strobe.
REQ-008 mem_wr  out  1  memory write strobe.
REQ-009 ld_ir  out  1  instruction register load.
REQ-010 inc_pc  out  1  program counter increment.
REQ-011 ld_pc  out  1  program counter load from the operand field (jump).
REQ-012 acc_load  out  1  drives the accumulator register's load input.
REQ-013 acc_ctrl  out  1  drives the accumulator's control input: 1 = load memory data, 0 = load ALU result.
REQ-014 data_e  out  1  enables the accumulator onto the data bus.
REQ-015 halted  out  1  high while in HALTED.
REQ-016 phase  out  3  current phase index, 0-7, for debug; 0 in HALTED.

Function
REQ-017 Opcodes SHALL be HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7; ALUOP = ADD|AND|XOR|LDA.
REQ-018 The FSM SHALL have states P0 INST_ADDR, P1 INST_FETCH, P2 INST_LOAD, P3 IDLE, P4 OP_ADDR, P5 OP_FETCH, P6 ALU_OP, P7 STORE and HALTED.
REQ-019 Running order: P0..P7 advance one per clock; P7 wraps to P0; an instruction takes exactly 8 cycles.
REQ-020 P4 with opcode==HLT SHALL go to HALTED instead of P5.
REQ-021 HALTED SHALL hold until start=1 is sampled, then go to P0; start is ignored in every other state.
REQ-022 Outputs SHALL be combinational decodes of the state and opcode. Any signal not listed for a state is 0.
- P0: addr_sel.
- P1: addr_sel, mem_rd.
- P2: addr_sel, mem_rd, ld_ir.
- P3: addr_sel, mem_rd, ld_ir.
- P4: inc_pc.
- P5: mem_rd if ALUOP.
- P6: mem_rd if ALUOP; inc_pc if SKZ and zero; ld_pc if JMP; data_e if STO.
- P7: mem_rd and acc_load if ALUOP; acc_ctrl if LDA; ld_pc if JMP; mem_wr and data_e if STO.
REQ-023 HALTED SHALL drive all strobes to 0 and halted to 1.
REQ-024 acc_load SHALL be high for exactly one cycle per ALUOP instruction and never for HLT, SKZ, STO or JMP.
REQ-025 opcode and zero SHALL be treated as stable from P3 to P7; the block does not register them.
REQ-026 mem_wr and acc_load SHALL never be high in the same cycle.

Reset
REQ-027 rst=1 SHALL force state P0 immediately, independent of clk. While reset is held: addr_sel=1, halted=0, phase=0, all other outputs 0.
REQ-028 Reset asserted mid-instruction, including from HALTED, SHALL abandon the instruction. The first rising edge after deassertion moves P0 to P1.

Structure
REQ-029 Shared package cpu_pkg SHALL hold the opcode enum (3-bit), the state enum and a constant for the phase count (8).
REQ-030 The block is a single module with no sub-modules. The state register is one always_ff block with async reset; output decode is one always_comb block.

Verification
REQ-031 Release reset with opcode=LDA held -> phase runs 0..7; ld_ir high at phases 2-3; acc_load=1 and acc_ctrl=1 only at phase 7; phase returns to 0 on cycle 8.
REQ-032 opcode=ADD -> acc_load=1 and acc_ctrl=0 at P7; mem_rd high at P1-P3 and P5-P7.
REQ-033 opcode=SKZ: zero=1 -> inc_pc high at P4 and P6 (2 pulses); zero=0 -> inc_pc at P4 only.
REQ-034 opcode=STO -> data_e at P6-P7, mem_wr at P7 only, acc_load never; opcode=JMP -> ld_pc at P6-P7.
REQ-035 opcode=HLT -> halted=1 from the cycle after P4; start held 0 for 20 cycles keeps halted and all strobes 0; a one-cycle start pulse -> P0 on the next edge.
REQ-036 rst pulsed asynchronously during P6 of STO -> mem_wr never asserts and the state is P0 before the next clk edge.
